// File: rtl/demux4_buffered_if.sv
// Upstream/downstream signal bundle for demux4_buffered: one input word plus
// destination select, and four independently handshaked output channels.
interface demux4_buffered_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] d;
  logic [1:0]       s;
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic [WIDTH-1:0] y3;
  logic [3:0]       yvalid;
  logic [3:0]       yready;

  modport master (
    output d, s, valid, yready,
    input  ready, y0, y1, y2, y3, yvalid
  );

  modport slave (
    input  d, s, valid, yready,
    output ready, y0, y1, y2, y3, yvalid
  );
endinterface

// File: rtl/demux4_buffered.sv
// 1-to-4 demultiplexer with a 2-entry FIFO per output channel; words are
// routed by s at the push edge and drained per channel by yready.
module demux4_buffered #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  demux4_buffered_if.slave    bus
);

  logic [WIDTH-1:0] mem [4][2];
  logic [1:0]       count [4];
  logic [3:0]       rd_ptr;
  logic [3:0]       wr_ptr;
  logic [3:0]       push;
  logic [3:0]       pop;
  logic [3:0]       nonempty;
  logic [WIDTH-1:0] head [4];

  // ready looks only at the selected channel's registered count, so there is
  // no combinational path from valid or yready.
  assign bus.ready = (count[bus.s] != 2'd2);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    push     = '0;
    pop      = '0;
    nonempty = '0;
    for (int i = 0; i < 4; i++) begin
      head[i]     = '0;
      nonempty[i] = (count[i] != 2'd0);
      push[i]     = bus.valid && bus.ready && (bus.s == 2'(i));
      pop[i]      = nonempty[i] && bus.yready[i];
      if (nonempty[i]) head[i] = mem[i][rd_ptr[i]];
    end
  end

  assign bus.yvalid = nonempty;
  assign bus.y0     = head[0];
  assign bus.y1     = head[1];
  assign bus.y2     = head[2];
  assign bus.y3     = head[3];

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < 4; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= ~wr_ptr[i];
        if (pop[i])  rd_ptr[i] <= ~rd_ptr[i];
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 2'd1;
          2'b01:   count[i] <= count[i] - 2'd1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; stale entries are
  // never visible because outputs are masked by the channel count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= bus.d;
    end
  end

endmodule

// File: doc/demux4_buffered.md
DEMUX4_BUFFERED -- requirements
Module: demux4_buffered

Interface
REQ-001 Parameter: WIDTH, default 4, data word width of the input and of every output channel.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: d  input  WIDTH  input data word.
REQ-005 Port: s  input  2  destination channel select (0..3).
REQ-006 Port: valid  input  1  upstream offers d/s this cycle.
REQ-007 Port: ready  output  1  block accepts d/s this cycle.
REQ-008 Port: y0, y1, y2, y3  output  WIDTH each  head word of channel 0..3.
REQ-009 Port: yvalid  output  4  bit i set: yi holds a valid word.
REQ-010 Port: yready  input  4  bit i set: downstream i consumes yi this cycle.

Function
REQ-011 The block SHALL contain four independent 2-entry FIFOs, one per channel, each with 1-bit read pointer, 1-bit write pointer and 2-bit count (legal values 0..2).
REQ-012 ready SHALL equal (count[s] != 2), depending only on s and registered state, with no combinational path from yready or valid.
REQ-013 Push: when valid && ready at a rising edge, d SHALL be written to channel s at its write pointer, write pointer toggles, count[s] increments.
REQ-014 Pop: when yvalid[i] && yready[i] at a rising edge, channel i read pointer SHALL toggle and count[i] decrements.
REQ-015 Simultaneous push and pop on the same channel SHALL leave count unchanged and move both pointers; only possible when count is 1 (count 0 has no pop, count 2 has no push per REQ-012).
REQ-016 Pushes and pops on different channels in the same cycle SHALL be fully independent.
REQ-017 yvalid[i] SHALL equal (count[i] != 0).
REQ-018 yi SHALL equal the entry at channel i read pointer when count[i] != 0, else all zeros.
REQ-019 Latency: a word pushed at edge N SHALL appear on yi with yvalid[i]=1 after edge N if channel i was empty (one-cycle latency).
REQ-020 Per-channel order SHALL be preserved; no word SHALL be lost, duplicated or routed to a channel other than the s sampled at its push.
REQ-021 valid && !ready SHALL cause no state change; upstream holds d, s, valid until accepted.
REQ-022 yready[i] while yvalid[i]=0 SHALL be ignored (no underflow, count stays 0).
REQ-023 Pointers SHALL wrap 1 -> 0 without affecting count.

Reset
REQ-024 While reset_n=0, independent of clk: all counts and pointers 0, yvalid=4'b0000, y0..y3 all zeros, ready=1.
REQ-025 Reset asserted mid-operation SHALL discard all stored words; first push after release behaves as on an empty block.
REQ-026 Storage array contents need not be reset; yi is masked by REQ-018.

Verification
REQ-027 Reset release, s=2, d=4'hA, valid=1 one cycle, yready=0 -> next cycle yvalid=4'b0100, y2=4'hA, y0/y1/y3=0, ready stays 1 for s=2.
REQ-028 Fill ch1 with 4'h3 then 4'h5, yready=0 -> ready=0 while s=1; a third offer 4'h7 with s=1 held is not accepted; ready=1 when s changes to 0.
REQ-029 Ch1 full (3,5), yready[1]=1 for two cycles -> y1 shows 3 then 5, then yvalid[1]=0, y1=0, ready=1 for s=1.
REQ-030 Ch3 holds 1 word 4'h9, same cycle push 4'hC to ch3 and yready[3]=1 -> count stays 1, y3=4'hC next cycle.
REQ-031 Round-robin s=0,1,2,3 with d=1,2,3,4, all yready=0 -> yvalid=4'b1111, y0..y3=1,2,3,4; yready=4'b1111 one cycle -> yvalid=4'b0000.
REQ-032 Ch0 and ch2 each holding words, reset_n pulsed low between edges -> yvalid=4'b0000, all y zero immediately; push 4'hF to ch0 after release -> y0=4'hF next cycle.
